// File: rtl/instr_fetch.sv
// BeeF instruction fetch stage: samples pc, runs a req/ack read against
// instruction memory and issues one word per fetch with a PC hold gate.
module instr_fetch #(
    parameter int         PCWidth  = 16,
    parameter logic [8:0] NOP_WORD = 9'h000,
    parameter int         TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PCWidth-1:0] pc,
    input  logic               flush,
    output logic [PCWidth-1:0] imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [8:0]         imem_rdata,
    output logic [8:0]         instruction,
    output logic               instr_valid,
    output logic               pc_hold,
    output logic               fetch_timeout
);

    localparam int CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    typedef enum logic [1:0] {
        LAUNCH,
        FETCH,
        ISSUE
    } state_e;

    state_e             state_q, state_d;
    logic [PCWidth-1:0] addr_q, addr_d;
    logic               req_q, req_d;
    logic [8:0]         instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               hold_q, hold_d;
    logic               to_q, to_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        instr_d = instr_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        unique case (state_q)
            LAUNCH: begin
                addr_d  = pc;
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (!drop_q && !flush) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                        hold_d  = 1'b0;
                        state_d = ISSUE;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = LAUNCH;
                    end
                end else begin
                    if (flush) drop_d = 1'b1;
                    // Counter saturates; the FSM keeps waiting after timeout.
                    if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntMax) to_d = 1'b1;
                end
            end
            ISSUE: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
                hold_d  = 1'b1;
                state_d = LAUNCH;
            end
            default: state_d = LAUNCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LAUNCH;
            addr_q  <= '0;
            req_q   <= 1'b0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            hold_q  <= 1'b1;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign imem_addr     = addr_q;
    assign imem_req      = req_q;
    assign instruction   = instr_q;
    assign instr_valid   = valid_q;
    assign pc_hold       = hold_q;
    assign fetch_timeout = to_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-fetch timeline model driven
// by a bench-side memory responder with chosen wait counts and flushes.
module tb_instr_fetch;

    localparam logic [8:0] NOP = 9'h000;
    localparam int         TO  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic        flush = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [8:0]  imem_rdata = '0;
    logic [8:0]  instruction;
    logic        instr_valid;
    logic        pc_hold;
    logic        fetch_timeout;

    int errors = 0;
    int checks = 0;
    bit to_sticky = 1'b0;

    instr_fetch #(
        .PCWidth (16),
        .NOP_WORD(NOP),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc           (pc),
        .flush        (flush),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .pc_hold      (pc_hold),
        .fetch_timeout(fetch_timeout)
    );

    always #5 clk = ~clk;

    // Entered at a negedge inside a LAUNCH cycle; returns at the negedge
    // of the next LAUNCH cycle. Cycle c: 0 LAUNCH, 1..w+1 FETCH, w+2 ISSUE.
    // fl = FETCH cycle carrying a flush pulse (-1: none).
    // rst_at = cycle at which reset is pulsed instead of continuing.
    task automatic run_fetch(input logic [15:0] p, input int w,
                             input int fl, input logic [8:0] d,
                             input int rst_at, input string tag);
        bit dropped;
        int last;
        dropped = (fl >= 1 && fl <= w + 1);
        last = dropped ? w + 1 : w + 2;
        for (int c = 0; c <= last; c++) begin
            logic       e_req, e_val;
            logic [8:0] e_ins;
            e_req = (c >= 1 && c <= w + 1);
            e_val = (!dropped && c == w + 2);
            e_ins = e_val ? d : NOP;
            if (e_req && (c - 1) >= TO) to_sticky = 1'b1;
            checks++;
            if (imem_req !== e_req) begin
                errors++;
                $display("FAIL %s req c=%0d got=%b exp=%b", tag, c, imem_req, e_req);
            end
            checks++;
            if (instr_valid !== e_val) begin
                errors++;
                $display("FAIL %s valid c=%0d got=%b exp=%b", tag, c, instr_valid, e_val);
            end
            checks++;
            if (pc_hold !== !e_val) begin
                errors++;
                $display("FAIL %s hold c=%0d got=%b exp=%b", tag, c, pc_hold, !e_val);
            end
            checks++;
            if (instruction !== e_ins) begin
                errors++;
                $display("FAIL %s instr c=%0d got=%h exp=%h", tag, c, instruction, e_ins);
            end
            checks++;
            if (fetch_timeout !== to_sticky) begin
                errors++;
                $display("FAIL %s timeout c=%0d got=%b exp=%b", tag, c, fetch_timeout, to_sticky);
            end
            if (e_req) begin
                checks++;
                if (imem_addr !== p) begin
                    errors++;
                    $display("FAIL %s addr c=%0d got=%h exp=%h", tag, c, imem_addr, p);
                end
            end
            if (c == rst_at) begin
                rst_n = 1'b0;
                imem_ack = 1'b0;
                flush = 1'b0;
                #1;
                to_sticky = 1'b0;
                checks++;
                if ({imem_req, instr_valid, pc_hold, fetch_timeout} !== 4'b0010 ||
                    instruction !== NOP || imem_addr !== 16'h0) begin
                    errors++;
                    $display("FAIL %s async_reset c=%0d got req=%b val=%b hold=%b to=%b ins=%h addr=%h exp 0 0 1 0 %h 0000",
                             tag, c, imem_req, instr_valid, pc_hold, fetch_timeout,
                             instruction, imem_addr, NOP);
                end
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (c == 0) pc = p;
            if (e_req) begin
                imem_ack = (c == w + 1);
                imem_rdata = imem_ack ? d : 9'($urandom);
                flush = (c == fl);
            end else begin
                imem_ack = 1'($urandom);
                imem_rdata = 9'($urandom);
                flush = 1'($urandom);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({imem_req, instr_valid, pc_hold, fetch_timeout} !== 4'b0010 ||
            instruction !== NOP || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset got req=%b val=%b hold=%b to=%b ins=%h addr=%h",
                     imem_req, instr_valid, pc_hold, fetch_timeout, instruction, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        run_fetch(16'h0000, 1, -1, 9'h0A5, -1, "single");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            run_fetch(16'(i), 0, -1, 9'($urandom), -1, "b2b");
    endtask

    task automatic test_wait5();
        run_fetch(16'h1234, 5, -1, 9'h1C3, -1, "wait5");
    endtask

    task automatic test_flush();
        run_fetch(16'h0040, 4, 2, 9'h111, -1, "flush_mid");
        run_fetch(16'h0041, 0, -1, 9'h122, -1, "after_flush");
        run_fetch(16'h0050, 3, 4, 9'h133, -1, "flush_ack");
        run_fetch(16'h0051, 2, -1, 9'h144, -1, "after_flush2");
    endtask

    task automatic test_timeout();
        run_fetch(16'h0700, 12, -1, 9'h1FF, -1, "timeout");
        run_fetch(16'h0701, 0, -1, 9'h0F0, -1, "timeout_sticky");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int w, fl;
            w = $urandom_range(0, 6);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w + 1) : -1;
            run_fetch(16'($urandom), w, fl, 9'($urandom), -1, "random");
        end
    endtask

    task automatic test_reset_mid();
        run_fetch(16'h0300, 7, -1, 9'h0AA, 3, "rst_fetch");
        run_fetch(16'h0301, 1, -1, 9'h0BB, -1, "post_rst1");
        run_fetch(16'h0302, 2, -1, 9'h0CC, 4, "rst_issue");
        run_fetch(16'h0303, 0, -1, 9'h0DD, -1, "post_rst2");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wait5();
        test_flush();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
